// File: rtl/video_st_pkg.sv
// Shared types and constants for the video Avalon-ST packetizer.
package video_st_pkg;

  localparam int DATA_W_DEF = 24;
  localparam logic [3:0] VIDEO_PKT_TYPE = 4'h0;

  typedef enum logic [1:0] {
    WAIT_SOF  = 2'd0,
    ACTIVE    = 2'd1,
    TERMINATE = 2'd2
  } wr_state_e;

  typedef enum logic [1:0] {
    R_IDLE   = 2'd0,
    R_HEADER = 2'd1,
    R_PIX    = 2'd2
  } rd_state_e;

  typedef struct packed {
    logic                  sof;
    logic                  eop;
    logic [DATA_W_DEF-1:0] data;
  } fifo_word_t;

endpackage

// File: rtl/sc_fifo.sv
// Single-clock show-ahead FIFO; full/empty are registered and a write is
// refused while full even if a read frees a slot in the same cycle.
module sc_fifo #(
  parameter int WIDTH = 26,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       rd,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     usedw
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wptr_r, rptr_r;
  logic [AW:0]      cnt_r, cnt_next_s;
  logic             full_r, empty_r, do_wr_s, do_rd_s;

  always_comb begin
    do_wr_s    = wr & ~full_r;
    do_rd_s    = rd & ~empty_r;
    cnt_next_s = cnt_r + (AW+1)'(do_wr_s) - (AW+1)'(do_rd_s);
  end

  always_ff @(posedge clk) begin
    if (do_wr_s) begin
      mem_r[wptr_r] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_r  <= '0;
      rptr_r  <= '0;
      cnt_r   <= '0;
      full_r  <= 1'b0;
      empty_r <= 1'b1;
    end else begin
      if (do_wr_s) wptr_r <= wptr_r + AW'(1);
      if (do_rd_s) rptr_r <= rptr_r + AW'(1);
      cnt_r   <= cnt_next_s;
      full_r  <= (cnt_next_s == (AW+1)'(DEPTH));
      empty_r <= (cnt_next_s == '0);
    end
  end

  assign rdata = mem_r[rptr_r];
  assign full  = full_r;
  assign empty = empty_r;
  assign usedw = cnt_r;

endmodule

// File: rtl/video_st_packetizer.sv
// Packs a free-running pixel stream into Avalon-ST video packets (type-0
// header + WIDTH*HEIGHT pixels), closing truncated frames with a filler EOP.
module video_st_packetizer
  import video_st_pkg::*;
#(
  parameter int WIDTH      = 640,
  parameter int HEIGHT     = 480,
  parameter int FIFO_DEPTH = 1024,
  parameter int DATA_W     = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              frame_start,
  input  logic              pix_valid,
  input  logic [DATA_W-1:0] pix_data,
  output logic [DATA_W-1:0] st_data,
  output logic              st_sop,
  output logic              st_eop,
  output logic              st_valid,
  input  logic              st_ready,
  output logic [15:0]       frame_count,
  output logic [15:0]       drop_count,
  output logic              busy
);

  localparam int FRAME_PIX = WIDTH * HEIGHT;
  localparam int PW        = $clog2(FRAME_PIX + 1);
  localparam int FW        = DATA_W + 2;
  localparam logic [PW-1:0] LAST_CNT = PW'(FRAME_PIX - 1);
  localparam logic SINGLE = (FRAME_PIX == 1);

  wr_state_e wst_r, wst_next_s;
  rd_state_e rst_r, rst_next_s;
  logic [PW-1:0]  pcnt_r, pcnt_next_s;
  logic [FW-1:0]  wdata_s, head_s;
  logic           wr_s, rd_s, drop_inc_s, frame_inc_s, last_s;
  logic           fifo_full_s, fifo_empty_s;
  logic [$clog2(FIFO_DEPTH):0] fifo_usedw_s;

  sc_fifo #(.WIDTH(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .wr    (wr_s),
    .wdata (wdata_s),
    .rd    (rd_s),
    .rdata (head_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .usedw (fifo_usedw_s)
  );

  // Write side: frame capture, pixel counting and truncation handling.
  always_comb begin
    wst_next_s  = wst_r;
    pcnt_next_s = pcnt_r;
    wr_s        = 1'b0;
    wdata_s     = '0;
    drop_inc_s  = 1'b0;
    last_s      = (pcnt_r == LAST_CNT);
    case (wst_r)
      WAIT_SOF: begin
        if (frame_start && pix_valid && enable) begin
          if (!fifo_full_s) begin
            wr_s        = 1'b1;
            wdata_s     = {1'b1, SINGLE, pix_data};
            pcnt_next_s = PW'(1);
            wst_next_s  = SINGLE ? WAIT_SOF : ACTIVE;
          end else begin
            drop_inc_s  = 1'b1;
          end
        end else begin
          wst_next_s = WAIT_SOF;
        end
      end
      ACTIVE: begin
        if (frame_start || (pix_valid && fifo_full_s)) begin
          drop_inc_s = 1'b1;
          wst_next_s = TERMINATE;
        end else if (pix_valid) begin
          wr_s        = 1'b1;
          wdata_s     = {1'b0, last_s, pix_data};
          pcnt_next_s = pcnt_r + PW'(1);
          wst_next_s  = last_s ? WAIT_SOF : ACTIVE;
        end else begin
          wst_next_s = ACTIVE;
        end
      end
      TERMINATE: begin
        if (!fifo_full_s) begin
          wr_s       = 1'b1;
          wdata_s    = {1'b0, 1'b1, {DATA_W{1'b0}}};
          wst_next_s = WAIT_SOF;
        end else begin
          wst_next_s = TERMINATE;
        end
      end
      default: wst_next_s = WAIT_SOF;
    endcase
  end

  // Write-side state, pixel counter and drop counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      wst_r      <= WAIT_SOF;
      pcnt_r     <= '0;
      drop_count <= 16'h0000;
    end else begin
      wst_r      <= wst_next_s;
      pcnt_r     <= pcnt_next_s;
      drop_count <= drop_count + 16'(drop_inc_s);
    end
  end

  // Read side: the header is shown as soon as a SOF word reaches the head,
  // without popping it, so the first pixel follows one cycle later.
  always_comb begin
    rst_next_s  = rst_r;
    st_valid    = 1'b0;
    st_sop      = 1'b0;
    st_eop      = 1'b0;
    st_data     = '0;
    rd_s        = 1'b0;
    frame_inc_s = 1'b0;
    case (rst_r)
      R_IDLE: begin
        if (!fifo_empty_s && head_s[FW-1]) begin
          st_valid   = 1'b1;
          st_sop     = 1'b1;
          st_data    = {{(DATA_W-4){1'b0}}, VIDEO_PKT_TYPE};
          rst_next_s = st_ready ? R_PIX : R_HEADER;
        end else if (!fifo_empty_s) begin
          rd_s = 1'b1;
        end else begin
          rst_next_s = R_IDLE;
        end
      end
      R_HEADER: begin
        st_valid   = 1'b1;
        st_sop     = 1'b1;
        st_data    = {{(DATA_W-4){1'b0}}, VIDEO_PKT_TYPE};
        rst_next_s = st_ready ? R_PIX : R_HEADER;
      end
      R_PIX: begin
        st_valid = ~fifo_empty_s;
        st_eop   = ~fifo_empty_s & head_s[FW-2];
        st_data  = head_s[DATA_W-1:0];
        if (!fifo_empty_s && st_ready) begin
          rd_s = 1'b1;
          if (head_s[FW-2]) begin
            frame_inc_s = 1'b1;
            rst_next_s  = R_IDLE;
          end else begin
            rst_next_s  = R_PIX;
          end
        end else begin
          rst_next_s = R_PIX;
        end
      end
      default: rst_next_s = R_IDLE;
    endcase
  end

  // Read-side state and completed-packet counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      rst_r       <= R_IDLE;
      frame_count <= 16'h0000;
    end else begin
      rst_r       <= rst_next_s;
      frame_count <= frame_count + 16'(frame_inc_s);
    end
  end

  assign busy = (wst_r != WAIT_SOF) || (fifo_usedw_s != '0);

endmodule

// File: tb/tb_video_st_packetizer.sv
// Directed + randomized bench for video_st_packetizer against a queue-based
// behavioural model (WIDTH=4, HEIGHT=2, FIFO_DEPTH=4).
module tb_video_st_packetizer;

  localparam int W = 4, H = 2, D = 4, DW = 24, NPIX = W * H;

  logic          clk = 1'b0;
  logic          reset, enable, frame_start, pix_valid, st_ready;
  logic [DW-1:0] pix_data, st_data;
  logic          st_sop, st_eop, st_valid, busy;
  logic [15:0]   frame_count, drop_count;

  always #5 clk = ~clk;

  video_st_packetizer #(.WIDTH(W), .HEIGHT(H), .FIFO_DEPTH(D), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset), .enable(enable), .frame_start(frame_start),
    .pix_valid(pix_valid), .pix_data(pix_data), .st_data(st_data),
    .st_sop(st_sop), .st_eop(st_eop), .st_valid(st_valid), .st_ready(st_ready),
    .frame_count(frame_count), .drop_count(drop_count), .busy(busy)
  );

  int vectors = 0, miscompares = 0;

  // Reference model: FIFO contents as {sof,eop,data} words, frame progress
  // (0 = waiting for frame, 1 = inside frame, 2 = owes a filler EOP).
  logic [25:0] mq[$];
  int          m_mode, m_got;
  bit          m_open;
  logic [15:0] m_fc, m_dc;
  logic [25:0] acc_log[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_mode = 0; m_got = 0; m_open = 1'b0; m_fc = 16'h0; m_dc = 16'h0;
  endtask

  task automatic cycle(input logic fs, input logic pv, input logic [DW-1:0] pd,
                       input logic rdy, input logic en, input logic rst);
    logic [25:0] h, wv;
    bit nonempty, full, do_wr, do_pop, e_valid, e_sop, e_eop, e_busy;
    logic [DW-1:0] e_data;
    @(negedge clk);
    reset = rst; frame_start = fs; pix_valid = pv; pix_data = pd; st_ready = rdy; enable = en;
    #1;
    nonempty = (mq.size() > 0);
    h = nonempty ? mq[0] : 26'h0;
    e_valid = 1'b0; e_sop = 1'b0; e_eop = 1'b0; e_data = '0;
    if (!m_open) begin
      if (nonempty && h[25]) begin e_valid = 1'b1; e_sop = 1'b1; end
    end else if (nonempty) begin
      e_valid = 1'b1; e_eop = h[24]; e_data = h[23:0];
    end
    e_busy = (m_mode != 0) || nonempty;
    check("st_valid", 32'(st_valid), 32'(e_valid));
    if (e_valid) begin
      check("st_sop", 32'(st_sop), 32'(e_sop));
      check("st_eop", 32'(st_eop), 32'(e_eop));
      check("st_data", 32'(st_data), 32'(e_data));
    end
    check("frame_count", 32'(frame_count), 32'(m_fc));
    check("drop_count", 32'(drop_count), 32'(m_dc));
    check("busy", 32'(busy), 32'(e_busy));
    if (st_valid && rdy && !rst) acc_log.push_back({st_sop, st_eop, st_data});
    if (rst) begin
      model_reset();
    end else begin
      full = (mq.size() == D); do_wr = 1'b0; do_pop = 1'b0; wv = 26'h0;
      case (m_mode)
        0: if (fs && pv && en) begin
             if (full) m_dc++;
             else begin
               do_wr = 1'b1; wv = {1'b1, (NPIX == 1), pd}; m_got = 1;
               m_mode = (NPIX == 1) ? 0 : 1;
             end
           end
        1: if (fs || (pv && full)) begin
             m_dc++; m_mode = 2;
           end else if (pv) begin
             m_got++; do_wr = 1'b1; wv = {1'b0, (m_got == NPIX), pd};
             if (m_got == NPIX) m_mode = 0;
           end
        default: if (!full) begin do_wr = 1'b1; wv = {2'b01, 24'h0}; m_mode = 0; end
      endcase
      if (!m_open) begin
        if (nonempty && h[25]) begin if (rdy) m_open = 1'b1; end
        else if (nonempty) do_pop = 1'b1;
      end else if (nonempty && rdy) begin
        do_pop = 1'b1;
        if (h[24]) begin m_fc++; m_open = 1'b0; end
      end
      if (do_pop) void'(mq.pop_front());
      if (do_wr) mq.push_back(wv);
    end
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 24'h0, rdy, 1'b1, 1'b0);
  endtask

  // Expected packet built from first principles: header, pixels 1..n, optional filler.
  task automatic check_packet(input string tag, input int n, input bit filler);
    logic [25:0] e;
    check({tag, "_len"}, 32'(acc_log.size()), 32'(n + 1 + (filler ? 1 : 0)));
    for (int i = 0; i < acc_log.size(); i++) begin
      if (i == 0)      e = {2'b10, 24'h0};
      else if (i <= n) e = {1'b0, (!filler && i == n), 24'(i)};
      else             e = {2'b01, 24'h0};
      check({tag, "_beat"}, 32'(acc_log[i]), 32'(e));
    end
    acc_log.delete();
  endtask

  task automatic full_frame(input logic rdy, input logic en);
    cycle(1'b1, 1'b1, 24'd1, rdy, en, 1'b0);
    for (int p = 2; p <= NPIX; p++) cycle(1'b0, 1'b1, 24'(p), rdy, en, 1'b0);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; frame_start = 1'b0; pix_valid = 1'b0;
    pix_data = '0; st_ready = 1'b0;
    repeat (3) @(posedge clk);
    model_reset();

    // Reset state, then nominal frame with st_ready held high.
    idle(2, 1'b1);
    full_frame(1'b1, 1'b1);
    idle(6, 1'b1);
    check_packet("nominal", NPIX, 1'b0);
    check("nominal_fc", 32'(frame_count), 32'd1);
    check("nominal_dc", 32'(drop_count), 32'd0);

    // Backpressure: ready toggles, pixels arrive every other cycle.
    for (int c = 0; c < 2 * NPIX; c++)
      cycle((c == 0), (c % 2 == 0), 24'(c / 2 + 1), (c % 2 == 1), 1'b1, 1'b0);
    for (int c = 0; c < 12; c++) cycle(1'b0, 1'b0, 24'h0, (c % 2 == 1), 1'b1, 1'b0);
    check_packet("backpressure", NPIX, 1'b0);
    check("bp_dc", 32'(drop_count), 32'd0);

    // Overflow: sink stalled for 20 cycles.
    full_frame(1'b0, 1'b1);
    idle(12, 1'b0);
    idle(10, 1'b1);
    check_packet("overflow", 4, 1'b1);
    check("ovf_dc", 32'(drop_count), 32'd1);
    check("ovf_fc", 32'(frame_count), 32'd3);

    // Short frame: early frame_start after pixel 5; the next frame is lost.
    cycle(1'b1, 1'b1, 24'd1, 1'b1, 1'b1, 1'b0);
    for (int p = 2; p <= 5; p++) cycle(1'b0, 1'b1, 24'(p), 1'b1, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 24'd99, 1'b1, 1'b1, 1'b0);
    for (int p = 2; p <= NPIX; p++) cycle(1'b0, 1'b1, 24'(p + 100), 1'b1, 1'b1, 1'b0);
    idle(6, 1'b1);
    check_packet("short", 5, 1'b1);
    check("short_dc", 32'(drop_count), 32'd2);

    // Extra pixels after a full frame are discarded; a disabled frame is ignored.
    full_frame(1'b1, 1'b1);
    for (int p = 0; p < 3; p++) cycle(1'b0, 1'b1, 24'(p + 50), 1'b1, 1'b1, 1'b0);
    idle(4, 1'b1);
    check_packet("extra", NPIX, 1'b0);
    full_frame(1'b1, 1'b0);
    check("disabled_busy", 32'(busy), 32'd0);
    idle(4, 1'b1);
    check("disabled_len", 32'(acc_log.size()), 32'd0);

    // Reset mid-packet, then a clean frame.
    cycle(1'b1, 1'b1, 24'd1, 1'b1, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 24'd2, 1'b1, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 24'd3, 1'b1, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 24'd4, 1'b1, 1'b1, 1'b1);
    idle(1, 1'b1);
    check("rst_valid", 32'(st_valid), 32'd0);
    check("rst_fc", 32'(frame_count), 32'd0);
    check("rst_dc", 32'(drop_count), 32'd0);
    acc_log.delete();
    full_frame(1'b1, 1'b1);
    idle(6, 1'b1);
    check_packet("after_reset", NPIX, 1'b0);

    // Randomized frames: random gaps, backpressure, disables and early starts.
    for (int f = 0; f < 30; f++) begin
      int rdy_pct;
      rdy_pct = $urandom_range(20, 100);
      cycle(1'b1, 1'b1, 24'($urandom), ($urandom_range(1, 100) <= rdy_pct),
            ($urandom_range(0, 5) != 0), 1'b0);
      for (int c = 0; c < 14; c++)
        cycle(($urandom_range(0, 30) == 0), ($urandom_range(0, 4) != 0), 24'($urandom),
              ($urandom_range(1, 100) <= rdy_pct), 1'b1, 1'b0);
      if ($urandom_range(0, 2) == 0) idle(12, 1'b1);
    end
    idle(20, 1'b1);
    acc_log.delete();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
